game_state_ctrl: RTL and testbench

Multi-pipe game-state controller for the Flappy VGA design: it decides when the bird has collided, counts how many pipes the bird has cleared, keeps the high score, and holds the lose screen for a minimum time before the game can return to idle. It sits between the pipe/bird position generators and the VGA renderer / seven-segment score display. The number of pipes checked at once, the coordinate width and the lose-hold time are set by parameters. Collision detection is vertical-gap based (the bird must stay inside each pipe's opening), with an optional forgiveness margin and a floor check.

---
 rtl/game_state_ctrl.sv | 150 +++++++++++++++
 tb/tb_game_state_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// Game-state controller for Flappy VGA: collision detection, pipe-pass scoring,
// high score tracking and a minimum-duration lose screen.
module game_state_ctrl #(
  parameter int NUM_PIPES = 4,
  parameter int COORD_W   = 10,
  parameter int SCORE_W   = 8,
  parameter int LOSE_HOLD = 1600,
  parameter int MARGIN    = 0,
  parameter int FLOOR_Y   = 470
) (
  input  logic                           Clk,
  input  logic                           reset,
  input  logic                           Start,
  input  logic                           Ack,
  input  logic                           Pause,
  input  logic [COORD_W-1:0]             Bird_X_L,
  input  logic [COORD_W-1:0]             Bird_X_R,
  input  logic [COORD_W-1:0]             Bird_Y_T,
  input  logic [COORD_W-1:0]             Bird_Y_B,
  input  logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_L,
  input  logic [NUM_PIPES*COORD_W-1:0]   Pipe_X_R,
  input  logic [NUM_PIPES*COORD_W-1:0]   Gap_Y_T,
  input  logic [NUM_PIPES*COORD_W-1:0]   Gap_Y_B,
  input  logic [NUM_PIPES-1:0]           Pipe_Valid,
  output logic                           Q_Initial,
  output logic                           Q_Check,
  output logic                           Q_Pause,
  output logic                           Q_Lose,
  output logic [SCORE_W-1:0]             Score,
  output logic [SCORE_W-1:0]             High_Score,
  output logic [NUM_PIPES-1:0]           Hit_Pipe
);

  localparam int CNT_W = (LOSE_HOLD < 1) ? 1 : $clog2(LOSE_HOLD + 1);
  localparam int PC_W  = $clog2(NUM_PIPES + 1) + 1;
  localparam logic [CNT_W-1:0]   HOLD_MAX  = CNT_W'(LOSE_HOLD);
  localparam logic [COORD_W:0]   MARGIN_X  = (COORD_W+1)'(MARGIN);
  localparam logic [COORD_W-1:0] FLOOR_C   = COORD_W'(FLOOR_Y);
  localparam logic [SCORE_W+PC_W-1:0] SCORE_MAX = (SCORE_W+PC_W)'({SCORE_W{1'b1}});

  typedef enum logic [3:0] {
    S_INITIAL = 4'b0001,
    S_CHECK   = 4'b0010,
    S_PAUSE   = 4'b0100,
    S_LOSE    = 4'b1000
  } state_t;

  state_t               state_reg, state_next;
  logic [SCORE_W-1:0]   score_reg, high_reg;
  logic [NUM_PIPES-1:0] hit_pipe_reg, passed_reg;
  logic [CNT_W-1:0]     hold_cnt_reg;

  logic [NUM_PIPES-1:0] hit, behind, newpass, recycle;
  logic                 floor_hit, collide;
  logic [PC_W-1:0]      pass_cnt;
  logic [SCORE_W+PC_W-1:0] score_sum;
  logic [SCORE_W-1:0]   score_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      logic [COORD_W-1:0] xl, xr, gt, gb;
      logic xov, outgap;
      assign xl = Pipe_X_L[gi*COORD_W +: COORD_W];
      assign xr = Pipe_X_R[gi*COORD_W +: COORD_W];
      assign gt = Gap_Y_T[gi*COORD_W +: COORD_W];
      assign gb = Gap_Y_B[gi*COORD_W +: COORD_W];
      // One extra bit on the margin sums keeps them from wrapping near the screen edge.
      assign xov = ({1'b0, Bird_X_R} > ({1'b0, xl} + MARGIN_X)) &&
                   (({1'b0, Bird_X_L} + MARGIN_X) < {1'b0, xr});
      assign outgap      = (Bird_Y_T < gt) || (Bird_Y_B > gb);
      assign hit[gi]     = Pipe_Valid[gi] & xov & outgap;
      assign behind[gi]  = xr < Bird_X_L;
      assign newpass[gi] = Pipe_Valid[gi] & ~passed_reg[gi] & behind[gi];
      assign recycle[gi] = ~Pipe_Valid[gi] | ~behind[gi];
    end
  endgenerate

  assign floor_hit = (Bird_Y_B >= FLOOR_C);
  assign collide   = (|hit) | floor_hit;

  always_comb begin
    pass_cnt = '0;
    for (int p = 0; p < NUM_PIPES; p++)
      pass_cnt = pass_cnt + PC_W'(newpass[p]);
    score_sum = (SCORE_W+PC_W)'(score_reg) + (SCORE_W+PC_W)'(pass_cnt);
    score_sat = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state_reg <= S_INITIAL;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INITIAL: if (Start) state_next = S_CHECK;
      S_CHECK: begin
        if (collide)    state_next = S_LOSE;
        else if (Pause) state_next = S_PAUSE;
      end
      S_PAUSE:   if (!Pause) state_next = S_CHECK;
      S_LOSE:    if (Ack && (hold_cnt_reg >= HOLD_MAX)) state_next = S_INITIAL;
      default:   state_next = S_INITIAL;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      score_reg    <= '0;
      high_reg     <= '0;
      hit_pipe_reg <= '0;
      passed_reg   <= '0;
      hold_cnt_reg <= '0;
    end else begin
      // Pipes back in front of the bird (or off screen) become eligible to score again.
      passed_reg <= passed_reg & ~recycle;
      case (state_reg)
        S_INITIAL: begin
          if (Start) begin
            score_reg    <= '0;
            hit_pipe_reg <= '0;
            passed_reg   <= behind;
          end
        end
        S_CHECK: begin
          if (collide) begin
            hit_pipe_reg <= hit;
            high_reg     <= (score_reg > high_reg) ? score_reg : high_reg;
            hold_cnt_reg <= '0;
          end else begin
            score_reg  <= score_sat;
            passed_reg <= (passed_reg & ~recycle) | newpass;
          end
        end
        S_LOSE: begin
          if (hold_cnt_reg < HOLD_MAX) hold_cnt_reg <= hold_cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign {Q_Lose, Q_Pause, Q_Check, Q_Initial} = state_reg;
  assign Score      = score_reg;
  assign High_Score = high_reg;
  assign Hit_Pipe   = hit_pipe_reg;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Table-driven bench for game_state_ctrl with two pipes and a short lose hold.
module tb_game_state_ctrl;

  localparam int NP = 2;
  localparam int CW = 10;
  localparam int SW = 8;

  logic Clk = 1'b0;
  logic reset, Start, Ack, Pause;
  logic [CW-1:0] Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B;
  logic [NP*CW-1:0] Pipe_X_L, Pipe_X_R, Gap_Y_T, Gap_Y_B;
  logic [NP-1:0] Pipe_Valid;
  logic Q_Initial, Q_Check, Q_Pause, Q_Lose;
  logic [SW-1:0] Score, High_Score;
  logic [NP-1:0] Hit_Pipe;

  game_state_ctrl #(
    .NUM_PIPES(NP), .COORD_W(CW), .SCORE_W(SW),
    .LOSE_HOLD(4), .MARGIN(0), .FLOOR_Y(470)
  ) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Pause(Pause),
    .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
    .Pipe_X_L(Pipe_X_L), .Pipe_X_R(Pipe_X_R), .Gap_Y_T(Gap_Y_T), .Gap_Y_B(Gap_Y_B),
    .Pipe_Valid(Pipe_Valid),
    .Q_Initial(Q_Initial), .Q_Check(Q_Check), .Q_Pause(Q_Pause), .Q_Lose(Q_Lose),
    .Score(Score), .High_Score(High_Score), .Hit_Pipe(Hit_Pipe)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic st, ak, pa;
    int   yt, yb;
    int   p0xl, p0xr, p0gt, p0gb;
    int   p1xl, p1xr, p1gt, p1gb;
    logic [1:0] valid;
    logic [3:0] eq;
    int   esc, ehs;
    logic [1:0] ehit;
  } vec_t;

  vec_t vecs[29];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic st, logic ak, logic pa, int yt, int yb,
                              int a0, int b0, int c0, int d0,
                              int a1, int b1, int c1, int d1,
                              logic [1:0] v, logic [3:0] q, int sc, int hs, logic [1:0] h);
    vec_t r;
    r.st = st; r.ak = ak; r.pa = pa; r.yt = yt; r.yb = yb;
    r.p0xl = a0; r.p0xr = b0; r.p0gt = c0; r.p0gb = d0;
    r.p1xl = a1; r.p1xr = b1; r.p1gt = c1; r.p1gb = d1;
    r.valid = v; r.eq = q; r.esc = sc; r.ehs = hs; r.ehit = h;
    return r;
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    Start = v.st; Ack = v.ak; Pause = v.pa;
    Bird_X_L = 10'd100; Bird_X_R = 10'd120;
    Bird_Y_T = CW'(v.yt); Bird_Y_B = CW'(v.yb);
    Pipe_X_L = {CW'(v.p1xl), CW'(v.p0xl)};
    Pipe_X_R = {CW'(v.p1xr), CW'(v.p0xr)};
    Gap_Y_T  = {CW'(v.p1gt), CW'(v.p0gt)};
    Gap_Y_B  = {CW'(v.p1gb), CW'(v.p0gb)};
    Pipe_Valid = v.valid;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] q, input int sc,
                            input int hs, input logic [1:0] h);
    check({tag, " state"}, int'({Q_Lose, Q_Pause, Q_Check, Q_Initial}), int'(q));
    check({tag, " score"}, int'(Score), sc);
    check({tag, " high"},  int'(High_Score), hs);
    check({tag, " hit"},   int'(Hit_Pipe), int'(h));
  endtask

  initial begin
    // st ak pa  yt  yb | pipe0 xl xr gt gb | pipe1 xl xr gt gb | valid | state score high hit
    vecs[0]  = mk(0,0,0,200,220, 110,140,180,240, 300,330,180,240, 2'b11, 4'b0001,0,0,2'b00);
    vecs[1]  = mk(1,0,0,200,220, 110,140,180,240, 300,330,180,240, 2'b11, 4'b0010,0,0,2'b00);
    vecs[2]  = mk(0,0,0,200,220, 110,140,180,240, 300,330,180,240, 2'b11, 4'b0010,0,0,2'b00);
    vecs[3]  = mk(0,0,0,200,220, 110,140,210,260, 300,330,180,240, 2'b11, 4'b1000,0,0,2'b01);
    for (int i = 4; i <= 7; i++)
      vecs[i] = mk(0,1,0,200,220, 110,140,210,260, 300,330,180,240, 2'b11, 4'b1000,0,0,2'b01);
    vecs[8]  = mk(0,1,0,200,220, 110,140,210,260, 300,330,180,240, 2'b11, 4'b0001,0,0,2'b01);
    vecs[9]  = mk(1,0,0,200,220, 100,130,180,240, 300,330,180,240, 2'b11, 4'b0010,0,0,2'b00);
    vecs[10] = mk(0,0,0,200,220,  65, 95,180,240, 300,330,180,240, 2'b11, 4'b0010,1,0,2'b00);
    vecs[11] = mk(0,0,0,200,220,  60, 90,180,240, 300,330,180,240, 2'b11, 4'b0010,1,0,2'b00);
    vecs[12] = mk(0,0,0,200,220, 130,160,180,240, 130,160,180,240, 2'b11, 4'b0010,1,0,2'b00);
    vecs[13] = mk(0,0,0,200,220,  60, 90,180,240,  60, 90,180,240, 2'b11, 4'b0010,3,0,2'b00);
    vecs[14] = mk(0,0,0,200,220, 130,160,180,240, 110,140,180,240, 2'b11, 4'b0010,3,0,2'b00);
    vecs[15] = mk(0,0,0,200,220,  60, 90,180,240, 110,140,210,260, 2'b11, 4'b1000,3,3,2'b10);
    for (int i = 16; i <= 18; i++)
      vecs[i] = mk(0,0,0,200,220, 60, 90,180,240, 110,140,210,260, 2'b11, 4'b1000,3,3,2'b10);
    vecs[19] = mk(0,1,0,200,220,  60, 90,180,240, 110,140,210,260, 2'b11, 4'b1000,3,3,2'b10);
    vecs[20] = mk(0,0,0,200,220,  60, 90,180,240, 110,140,210,260, 2'b11, 4'b1000,3,3,2'b10);
    vecs[21] = mk(0,1,0,200,220,  60, 90,180,240, 110,140,210,260, 2'b11, 4'b0001,3,3,2'b10);
    vecs[22] = mk(1,0,0,200,220, 130,160,180,240, 300,330,180,240, 2'b11, 4'b0010,0,3,2'b00);
    vecs[23] = mk(0,0,1,200,220, 130,160,180,240, 300,330,180,240, 2'b11, 4'b0100,0,3,2'b00);
    vecs[24] = mk(1,1,1,200,220, 110,140,210,260, 300,330,180,240, 2'b11, 4'b0100,0,3,2'b00);
    vecs[25] = mk(0,0,0,200,220, 130,160,180,240, 300,330,180,240, 2'b11, 4'b0010,0,3,2'b00);
    vecs[26] = mk(0,0,0,200,220, 110,140,210,260, 300,330,180,240, 2'b10, 4'b0010,0,3,2'b00);
    vecs[27] = mk(0,0,0,449,469, 130,160,180,240, 300,330,180,240, 2'b11, 4'b0010,0,3,2'b00);
    vecs[28] = mk(0,0,0,450,470, 130,160,180,240, 300,330,180,240, 2'b11, 4'b1000,0,3,2'b00);

    reset = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge Clk);
    #1 reset = 1'b0;
    check_outs("reset", 4'b0001, 0, 0, 2'b00);

    for (int i = 0; i < 29; i++) begin
      drive(vecs[i]);
      @(posedge Clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].eq, vecs[i].esc, vecs[i].ehs, vecs[i].ehit);
      $display("vec %0d: state=%b score=%0d high=%0d hit=%b", i,
               {Q_Lose, Q_Pause, Q_Check, Q_Initial}, Score, High_Score, Hit_Pipe);
    end

    // Asynchronous reset mid-game clears everything, high score included, without a clock edge.
    #2 reset = 1'b1;
    #1 check_outs("async_reset", 4'b0001, 0, 0, 2'b00);
    @(posedge Clk);
    #1 reset = 1'b0;

    // A collision on the same cycle as Pause wins and goes to LOSE.
    drive(mk(1,0,0,200,220, 130,160,180,240, 300,330,180,240, 2'b11, 4'b0010,0,0,2'b00));
    @(posedge Clk);
    #1 check_outs("restart", 4'b0010, 0, 0, 2'b00);
    drive(mk(0,0,1,200,220, 110,140,210,260, 300,330,180,240, 2'b11, 4'b1000,0,0,2'b01));
    @(posedge Clk);
    #1 check_outs("pause_vs_hit", 4'b1000, 0, 0, 2'b01);
    $display("pause_vs_hit: state=%b hit=%b", {Q_Lose, Q_Pause, Q_Check, Q_Initial}, Hit_Pipe);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
